serial_out_scheduler: RTL and testbench
=======================================

SERIAL_OUT_SCHEDULER -- requirements
Module: serial_out_scheduler

Interface
REQ-001 SHALL provide parameter OUTPUT_NUM, default 16, number of serial_out channels sequenced.
REQ-002 SHALL provide parameter DELAY_BIT, default 16, width of per-channel start delay and timebase.
REQ-003 SHALL provide port clk, input, 1, clock.
REQ-004 SHALL provide port rst_n, input, 1; reset rst_n, asynchronous, active-low; clock clk.
REQ-005 SHALL provide port i_cfg_we, input, 1, per-channel config write strobe.
REQ-006 SHALL provide port i_cfg_sel, input, 4, channel index for config write.
REQ-007 SHALL provide port i_cfg_delay, input, DELAY_BIT, start delay in clk cycles.
REQ-008 SHALL provide port i_cfg_enable, input, 1, channel participates in the sequence.
REQ-009 SHALL provide port i_trigger, input, 1, one-cycle sequence start request.
REQ-010 SHALL provide port i_abort, input, 1, one-cycle sequence cancel request.
REQ-011 SHALL provide port i_ch_done_tick, input, OUTPUT_NUM, per-channel done pulses from serial_out.
REQ-012 SHALL provide port o_ch_start, output, OUTPUT_NUM, per-channel one-cycle start pulses.
REQ-013 SHALL provide port o_ch_stop, output, OUTPUT_NUM, per-channel one-cycle stop pulses.
REQ-014 SHALL provide port o_busy, output, 1, high in RUN and WAIT.
REQ-015 SHALL provide port o_done_tick, output, 1, one-cycle sequence-complete pulse.

Function
REQ-016 SHALL hold per-channel registers delay[k] (DELAY_BIT) and enable[k] (1 bit), plus started and finished masks (OUTPUT_NUM bits each).
REQ-017 SHALL, in IDLE only, write i_cfg_delay/i_cfg_enable into channel i_cfg_sel on i_cfg_we; writes in other states are ignored; i_cfg_sel >= OUTPUT_NUM is ignored.
REQ-018 SHALL implement states IDLE, RUN, WAIT, DONE.
REQ-019 IDLE: i_trigger with enable mask nonzero -> RUN, clear timebase, started and finished; with enable mask zero -> DONE.
REQ-020 RUN: timebase increments by 1 per cycle from 0 and saturates at all-ones (no wrap).
REQ-021 RUN: in the cycle timebase == delay[k], enable[k]=1, started[k]=0, o_ch_start[k] SHALL pulse for exactly one cycle and started[k] is set; equal delays start simultaneously.
REQ-022 Timing: trigger sampled at edge T; channel with delay d pulses o_ch_start in the cycle after edge T+d.
REQ-023 RUN -> WAIT in the cycle after the last enabled channel's start pulse.
REQ-024 RUN and WAIT: i_ch_done_tick[k] sets finished[k] only if started[k]=1 at that cycle; other done ticks are ignored.
REQ-025 WAIT -> DONE when finished equals enable mask (including done ticks arriving in the current cycle is not required; evaluation uses registered masks).
REQ-026 DONE: o_done_tick=1 for one cycle, -> IDLE.
REQ-027 i_abort in RUN or WAIT: o_ch_stop = started mask for one cycle, -> IDLE, no o_done_tick; abort has priority over all other transitions in the same cycle.
REQ-028 i_abort in IDLE or DONE SHALL be ignored; i_trigger outside IDLE SHALL be ignored.
REQ-029 o_ch_start, o_ch_stop, o_done_tick SHALL be registered outputs; o_busy SHALL be decoded from state register.

Reset
REQ-030 On rst_n low, state=IDLE, timebase=0, delay[k]=0, enable[k]=0, started=finished=0, all outputs 0, immediately and asynchronously.
REQ-031 Reset mid-sequence SHALL drop all pending starts without issuing stop pulses.

Verification
REQ-032 Program ch0 delay 0, ch3 delay 5, ch7 delay 5 enabled; trigger at edge T -> o_ch_start[0] after T, [3] and [7] together after T+5; o_busy high; WAIT after.
REQ-033 Same setup, pulse done ticks on 0,3,7 -> o_done_tick one cycle after last finished update, then IDLE, o_busy low.
REQ-034 All channels disabled, trigger -> o_done_tick pulse, no o_ch_start activity.
REQ-035 ch2 delay 10 enabled, ch4 delay 2 enabled; abort at timebase 5 -> o_ch_stop = 16'h0010 for one cycle, ch2 never started, no o_done_tick.
REQ-036 Config write and second trigger during RUN -> ignored, delay register unchanged, sequence completes normally; done tick on unstarted channel -> ignored.
REQ-037 rst_n asserted during WAIT -> all outputs 0 at once, enable/delay cleared, subsequent trigger goes to DONE.

Source files
------------

// File: rtl/serial_out_scheduler.sv
// Sequences per-channel start pulses at programmed delays after a trigger, then
// waits for every started channel to report done (or an abort) before returning idle.
module serial_out_scheduler #(
   parameter int unsigned OUTPUT_NUM = 16,
   parameter int unsigned DELAY_BIT  = 16
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  i_cfg_we,
   input  logic [3:0]            i_cfg_sel,
   input  logic [DELAY_BIT-1:0]  i_cfg_delay,
   input  logic                  i_cfg_enable,
   input  logic                  i_trigger,
   input  logic                  i_abort,
   input  logic [OUTPUT_NUM-1:0] i_ch_done_tick,
   output logic [OUTPUT_NUM-1:0] o_ch_start,
   output logic [OUTPUT_NUM-1:0] o_ch_stop,
   output logic                  o_busy,
   output logic                  o_done_tick
);

   typedef enum logic [1:0] {IDLE, RUN, WAIT, DONE} state_e;

   state_e                  state_q, state_d;
   logic [DELAY_BIT-1:0]    tb_q, tb_d, tb_inc;
   logic [DELAY_BIT-1:0]    delay_q [OUTPUT_NUM];
   logic [DELAY_BIT-1:0]    delay_d [OUTPUT_NUM];
   logic [OUTPUT_NUM-1:0]   enable_q, enable_d;
   logic [OUTPUT_NUM-1:0]   started_q, started_d;
   logic [OUTPUT_NUM-1:0]   finished_q, finished_d;
   logic [OUTPUT_NUM-1:0]   ch_start_q, ch_start_d;
   logic [OUTPUT_NUM-1:0]   ch_stop_q, ch_stop_d;
   logic                    done_tick_q, done_tick_d;
   logic [OUTPUT_NUM-1:0]   hit_zero, hit_inc;

   // Start matches are evaluated against the timebase value the next edge will load,
   // so the registered start pulse lines up with the cycle where timebase == delay.
   always_comb begin
      tb_inc   = (tb_q == '1) ? tb_q : tb_q + DELAY_BIT'(1);
      hit_zero = '0;
      hit_inc  = '0;
      for (int unsigned k = 0; k < OUTPUT_NUM; k++) begin
         hit_zero[k] = enable_q[k] && (delay_q[k] == '0);
         hit_inc[k]  = enable_q[k] && (delay_q[k] == tb_inc);
      end
   end

   // Next-state and registered-output decode
   always_comb begin
      state_d     = state_q;
      tb_d        = tb_q;
      delay_d     = delay_q;
      enable_d    = enable_q;
      started_d   = started_q;
      finished_d  = finished_q;
      ch_start_d  = '0;
      ch_stop_d   = '0;
      done_tick_d = 1'b0;

      unique case (state_q)
         IDLE: begin
            if (i_cfg_we) begin
               for (int unsigned k = 0; k < OUTPUT_NUM; k++) begin
                  if (32'(i_cfg_sel) == k) begin
                     delay_d[k]  = i_cfg_delay;
                     enable_d[k] = i_cfg_enable;
                  end
               end
            end
            if (i_trigger) begin
               if (enable_q != '0) begin
                  state_d    = RUN;
                  tb_d       = '0;
                  finished_d = '0;
                  ch_start_d = hit_zero;
                  started_d  = hit_zero;
               end else begin
                  state_d     = DONE;
                  done_tick_d = 1'b1;
               end
            end
         end

         RUN: begin
            if (i_abort) begin
               state_d   = IDLE;
               ch_stop_d = started_q;
            end else begin
               finished_d = finished_q | (i_ch_done_tick & started_q);
               if (started_q == enable_q) begin
                  state_d = WAIT;
               end else begin
                  tb_d       = tb_inc;
                  ch_start_d = hit_inc & ~started_q;
                  started_d  = started_q | (hit_inc & ~started_q);
               end
            end
         end

         WAIT: begin
            if (i_abort) begin
               state_d   = IDLE;
               ch_stop_d = started_q;
            end else begin
               finished_d = finished_q | (i_ch_done_tick & started_q);
               if (finished_q == enable_q) begin
                  state_d     = DONE;
                  done_tick_d = 1'b1;
               end
            end
         end

         DONE: state_d = IDLE;

         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         tb_q        <= '0;
         enable_q    <= '0;
         started_q   <= '0;
         finished_q  <= '0;
         ch_start_q  <= '0;
         ch_stop_q   <= '0;
         done_tick_q <= 1'b0;
         for (int unsigned k = 0; k < OUTPUT_NUM; k++) begin
            delay_q[k] <= '0;
         end
      end else begin
         state_q     <= state_d;
         tb_q        <= tb_d;
         enable_q    <= enable_d;
         started_q   <= started_d;
         finished_q  <= finished_d;
         ch_start_q  <= ch_start_d;
         ch_stop_q   <= ch_stop_d;
         done_tick_q <= done_tick_d;
         for (int unsigned k = 0; k < OUTPUT_NUM; k++) begin
            delay_q[k] <= delay_d[k];
         end
      end
   end

   assign o_ch_start  = ch_start_q;
   assign o_ch_stop   = ch_stop_q;
   assign o_done_tick = done_tick_q;
   assign o_busy      = (state_q == RUN) || (state_q == WAIT);

endmodule

// File: tb/tb_serial_out_scheduler.sv
// Cycle-accurate vector bench for serial_out_scheduler: each record gives the inputs
// for one clock and the outputs expected right after that clock's rising edge.
module tb_serial_out_scheduler;

   localparam int unsigned N  = 16;
   localparam int unsigned DB = 16;

   typedef struct {
      logic [N-1:0] start;
      logic [N-1:0] stop;
      logic         busy;
      logic         done;
   } exp_t;

   typedef struct {
      logic          trig;
      logic          abort;
      logic [N-1:0]  done_tick;
      logic          we;
      logic [3:0]    sel;
      logic [DB-1:0] dly;
      logic          en;
      exp_t          e;
   } vec_t;

   logic          clk;
   logic          rst_n;
   logic          i_cfg_we;
   logic [3:0]    i_cfg_sel;
   logic [DB-1:0] i_cfg_delay;
   logic          i_cfg_enable;
   logic          i_trigger;
   logic          i_abort;
   logic [N-1:0]  i_ch_done_tick;
   logic [N-1:0]  o_ch_start;
   logic [N-1:0]  o_ch_stop;
   logic          o_busy;
   logic          o_done_tick;

   int unsigned errors = 0;
   int unsigned checks = 0;
   exp_t        sb[$];
   vec_t        tbl[$];

   serial_out_scheduler #(.OUTPUT_NUM(N), .DELAY_BIT(DB)) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .i_cfg_we       (i_cfg_we),
      .i_cfg_sel      (i_cfg_sel),
      .i_cfg_delay    (i_cfg_delay),
      .i_cfg_enable   (i_cfg_enable),
      .i_trigger      (i_trigger),
      .i_abort        (i_abort),
      .i_ch_done_tick (i_ch_done_tick),
      .o_ch_start     (o_ch_start),
      .o_ch_stop      (o_ch_stop),
      .o_busy         (o_busy),
      .o_done_tick    (o_done_tick)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic vec_t mkv(input logic trig, input logic abort, input logic [N-1:0] dt,
                                input logic we, input logic [3:0] sel, input logic [DB-1:0] dly,
                                input logic en, input logic [N-1:0] es, input logic [N-1:0] estop,
                                input logic eb, input logic ed);
      vec_t v;
      v.trig = trig; v.abort = abort; v.done_tick = dt;
      v.we = we; v.sel = sel; v.dly = dly; v.en = en;
      v.e.start = es; v.e.stop = estop; v.e.busy = eb; v.e.done = ed;
      return v;
   endfunction

   function automatic vec_t idle(input logic [N-1:0] es, input logic eb, input logic ed);
      return mkv(1'b0, 1'b0, '0, 1'b0, 4'd0, '0, 1'b0, es, '0, eb, ed);
   endfunction

   function automatic vec_t cfg(input logic [3:0] sel, input logic [DB-1:0] dly, input logic en);
      return mkv(1'b0, 1'b0, '0, 1'b1, sel, dly, en, '0, '0, 1'b0, 1'b0);
   endfunction

   task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic check(input string nm);
      exp_t e;
      if (sb.size() == 0) begin
         checks++;
         errors++;
         $display("FAIL %s: got empty scoreboard expected an entry", nm);
         return;
      end
      e = sb.pop_front();
      cmp({nm, ".start"}, 32'(o_ch_start), 32'(e.start));
      cmp({nm, ".stop"},  32'(o_ch_stop),  32'(e.stop));
      cmp({nm, ".busy"},  32'(o_busy),     32'(e.busy));
      cmp({nm, ".done"},  32'(o_done_tick), 32'(e.done));
   endtask

   task automatic step(input vec_t v, input string nm);
      i_trigger      = v.trig;
      i_abort        = v.abort;
      i_ch_done_tick = v.done_tick;
      i_cfg_we       = v.we;
      i_cfg_sel      = v.sel;
      i_cfg_delay    = v.dly;
      i_cfg_enable   = v.en;
      sb.push_back(v.e);
      @(posedge clk);
      #1;
      check(nm);
   endtask

   initial begin
      exp_t z;
      z.start = '0; z.stop = '0; z.busy = 1'b0; z.done = 1'b0;

      // Sequence: ch0 d0, ch3/ch7 d5; done ticks complete it
      tbl.push_back(cfg(4'd0, 16'd0, 1'b1));
      tbl.push_back(cfg(4'd3, 16'd5, 1'b1));
      tbl.push_back(cfg(4'd7, 16'd5, 1'b1));
      tbl.push_back(mkv(1, 0, '0, 0, 0, '0, 0, 16'h0001, '0, 1, 0));
      for (int i = 1; i <= 4; i++) tbl.push_back(idle('0, 1, 0));
      tbl.push_back(idle(16'h0088, 1, 0));
      tbl.push_back(mkv(0, 0, 16'h0001, 0, 0, '0, 0, '0, '0, 1, 0));
      tbl.push_back(mkv(0, 0, 16'h0088, 0, 0, '0, 0, '0, '0, 1, 0));
      tbl.push_back(idle('0, 0, 1));
      tbl.push_back(idle('0, 0, 0));
      // Config write, retrigger and unstarted done tick during RUN are ignored
      tbl.push_back(mkv(1, 0, '0, 0, 0, '0, 0, 16'h0001, '0, 1, 0));
      tbl.push_back(mkv(0, 0, '0, 1, 4'd3, 16'd3, 1, '0, '0, 1, 0));
      tbl.push_back(mkv(1, 0, 16'h0008, 0, 0, '0, 0, '0, '0, 1, 0));
      tbl.push_back(idle('0, 1, 0));
      tbl.push_back(idle('0, 1, 0));
      tbl.push_back(idle(16'h0088, 1, 0));
      tbl.push_back(mkv(0, 0, 16'h0081, 0, 0, '0, 0, '0, '0, 1, 0));
      tbl.push_back(idle('0, 1, 0));
      tbl.push_back(mkv(0, 0, 16'h0008, 0, 0, '0, 0, '0, '0, 1, 0));
      tbl.push_back(idle('0, 0, 1));
      tbl.push_back(idle('0, 0, 0));
      // All channels disabled: trigger goes straight to DONE
      tbl.push_back(cfg(4'd0, 16'd0, 1'b0));
      tbl.push_back(cfg(4'd3, 16'd5, 1'b0));
      tbl.push_back(cfg(4'd7, 16'd5, 1'b0));
      tbl.push_back(mkv(1, 0, '0, 0, 0, '0, 0, '0, '0, 0, 1));
      tbl.push_back(idle('0, 0, 0));
      // Abort at timebase 5 with ch4 started and ch2 pending; abort in IDLE ignored
      tbl.push_back(cfg(4'd2, 16'd10, 1'b1));
      tbl.push_back(cfg(4'd4, 16'd2, 1'b1));
      tbl.push_back(mkv(1, 0, '0, 0, 0, '0, 0, '0, '0, 1, 0));
      tbl.push_back(idle('0, 1, 0));
      tbl.push_back(idle(16'h0010, 1, 0));
      for (int i = 3; i <= 5; i++) tbl.push_back(idle('0, 1, 0));
      tbl.push_back(mkv(0, 1, '0, 0, 0, '0, 0, '0, 16'h0010, 0, 0));
      tbl.push_back(idle('0, 0, 0));
      tbl.push_back(mkv(0, 1, '0, 0, 0, '0, 0, '0, '0, 0, 0));
      for (int i = 0; i < 6; i++) tbl.push_back(idle('0, 0, 0));

      rst_n = 1'b1;
      i_trigger = 0; i_abort = 0; i_ch_done_tick = '0;
      i_cfg_we = 0; i_cfg_sel = '0; i_cfg_delay = '0; i_cfg_enable = 0;
      #1 rst_n = 1'b0;
      #1;
      sb.push_back(z);
      check("reset");
      @(negedge clk);
      rst_n = 1'b1;

      for (int i = 0; i < tbl.size(); i++) step(tbl[i], $sformatf("row%0d", i));

      // Reset asserted asynchronously while waiting for done ticks
      step(mkv(1, 0, '0, 0, 0, '0, 0, '0, '0, 1, 0), "rs_trig");
      for (int i = 1; i <= 11; i++)
         step(idle((i == 2) ? 16'h0010 : (i == 10) ? 16'h0004 : 16'h0000, 1, 0),
              $sformatf("rs%0d", i));
      #2 rst_n = 1'b0;
      #1;
      sb.push_back(z);
      check("async_rst");
      @(negedge clk);
      rst_n = 1'b1;
      step(mkv(1, 0, '0, 0, 0, '0, 0, '0, '0, 0, 1), "post_rst_trig");
      step(idle('0, 0, 0), "post_rst_idle");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
